axi_stream_remove_header: RTL and testbench
===========================================

AXI_STREAM_REMOVE_HEADER -- requirements
Module: axi_stream_remove_header

Interface
REQ-001 SHALL have parameter DATA_WD, default 32, data width in bits (multiple of 8, at least 16).
REQ-002 SHALL have parameter DATA_BYTE_WD, default DATA_WD/8, bytes per beat (W).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 SHALL have port strip_len, input, clog2(W+1) bits, header bytes to remove (N, 0..W), sampled on each packet's first accepted beat.
REQ-006 SHALL have ports s_axis_tvalid/tdata/tkeep/tlast (inputs: 1, DATA_WD, W, 1 bits) and s_axis_tready (output, 1 bit) carrying packets with the header in front.
REQ-007 SHALL have ports m_axis_tvalid/tdata/tkeep/tlast (outputs: 1, DATA_WD, W, 1 bits) and m_axis_tready (input, 1 bit) carrying packets with the header removed.
REQ-008 SHALL have port drop_pulse, output, 1 bit, one-cycle pulse when a whole packet is consumed by stripping.

Function
REQ-009 SHALL treat byte W-1 (tdata[DATA_WD-1 -: 8]) as the first byte; all tkeep contiguous and MSB-aligned; non-last input beats carry tkeep all ones.
REQ-010 SHALL register all m_axis outputs; s_axis_tready = (state != FLUSH) && (!m_axis_tvalid || m_axis_tready).
REQ-011 SHALL hold m_axis_tdata/tkeep/tlast stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-012 SHALL implement states FIRST (awaiting first beat), MERGE (mid-packet), FLUSH (emitting leftover beat); reset state FIRST.
REQ-013 FIRST, N=0: SHALL pass the beat unchanged, one cycle latency; go MERGE, or stay FIRST if tlast.
REQ-014 FIRST, N=W: SHALL discard the beat; go MERGE with residual count R=0 (pure pass-through after), or stay FIRST with drop_pulse if tlast.
REQ-015 FIRST, 0<N<W, not tlast: SHALL emit nothing, store the low W-N bytes as residual (R=W-N), go MERGE.
REQ-016 FIRST, tlast with kept-byte count K: K<=N SHALL emit nothing and pulse drop_pulse; K>N SHALL emit K-N bytes MSB-aligned with tlast=1.
REQ-017 MERGE, R>0, beat with K bytes: output = R residual bytes followed by first W-R input bytes; new residual = remaining bytes.
REQ-018 MERGE, tlast, R+K<=W: SHALL emit one beat, tkeep = top R+K bits set, tlast=1, return FIRST.
REQ-019 MERGE, tlast, R+K>W: SHALL emit full beat tlast=0, enter FLUSH, then emit R+K-W bytes MSB-aligned with tlast=1, return FIRST.
REQ-020 MERGE, R=0: SHALL pass beats unchanged.
REQ-021 SHALL use tdata bytes outside tkeep as zero on output.
REQ-022 SHALL ignore strip_len changes mid-packet; values above W SHALL be clamped to W.
REQ-023 SHALL allow back-to-back packets: FLUSH/last output in same cycle a new first beat is accepted is prohibited only in FLUSH (ready low).

Reset
REQ-024 On rst_n=0 asynchronously: m_axis_tvalid=0, tdata=0, tkeep=0, tlast=0, drop_pulse=0, state FIRST, residual and R cleared.
REQ-025 Reset mid-packet SHALL discard the partial packet; first beat after release is treated as a new packet header.

Configuration
REQ-026 Macro AXIS_RM_HDR_STAT_EN SHALL add outputs pkt_cnt[15:0] and drop_cnt[15:0] (reset 0, wrap at 0xFFFF) counting emitted packets (tlast handshakes) and drop_pulse events.
REQ-027 Without AXIS_RM_HDR_STAT_EN those ports and counters SHALL not exist; datapath behaviour is identical.

Verification (W=4)
REQ-028 N=0: 0x11223344, 0x55667788 keep F last -> identical beats out, 1-cycle latency.
REQ-029 N=2: 0xAABB1122, 0x33445566 keep F last -> 0x11223344 keep F, then 0x55660000 keep C last.
REQ-030 N=1: 0xAA112233, 0x44556677 keep E last -> 0x11223344 keep F, FLUSH 0x55660000 keep C last; s_axis_tready low during FLUSH.
REQ-031 N=3: single beat 0xAABBCC00 keep E last -> no output, drop_pulse one cycle (drop_cnt=1 with macro).
REQ-032 N=2, m_axis_tready low 3 cycles during FLUSH -> outputs held stable, no beat lost or duplicated.
REQ-033 rst_n low mid-packet after 1 beat -> outputs 0 same cycle; next packet 0xAABB1122 N=2 starts fresh (residual 0x1122).

Source files
------------

// File: rtl/axi_stream_remove_header.sv
// axi_stream_remove_header
// Strips a run-time selectable number of leading header bytes (strip_len)
// from each AXI-Stream packet and re-packs the remaining payload so that
// every output beat is full except the last. Byte W-1 (tdata MSB) is the
// first byte on the wire; tkeep is contiguous and MSB-aligned.
// Optional feature: define AXIS_RM_HDR_STAT_EN to add pkt_cnt/drop_cnt.
module axi_stream_remove_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [$clog2(DATA_BYTE_WD+1)-1:0]     strip_len,
  input  logic                                  s_axis_tvalid,
  input  logic [DATA_WD-1:0]                    s_axis_tdata,
  input  logic [DATA_BYTE_WD-1:0]               s_axis_tkeep,
  input  logic                                  s_axis_tlast,
  output logic                                  s_axis_tready,
  output logic                                  m_axis_tvalid,
  output logic [DATA_WD-1:0]                    m_axis_tdata,
  output logic [DATA_BYTE_WD-1:0]               m_axis_tkeep,
  output logic                                  m_axis_tlast,
  input  logic                                  m_axis_tready,
  output logic                                  drop_pulse
`ifdef AXIS_RM_HDR_STAT_EN
  ,
  output logic [15:0]                           pkt_cnt,
  output logic [15:0]                           drop_cnt
`endif
);

  localparam int SW = $clog2(DATA_BYTE_WD + 1);  // byte-count width (0..W)
  localparam int CW = SW + 1;                     // holds residual + beat (< 2W)
  localparam logic [SW-1:0] W_CNT = SW'(DATA_BYTE_WD);

  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_MERGE = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // tkeep with the top cnt bits set (cnt <= W)
  function automatic logic [DATA_BYTE_WD-1:0] keep_of(input logic [CW-1:0] cnt);
    logic [DATA_BYTE_WD-1:0] k;
    k = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      k[DATA_BYTE_WD-1-i] = (CW'(i) < cnt);
    end
    return k;
  endfunction

  // number of kept bytes in a beat
  function automatic logic [CW-1:0] count_keep(input logic [DATA_BYTE_WD-1:0] keep);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      c = c + CW'(keep[i]);
    end
    return c;
  endfunction

  // expand tkeep to a per-bit data mask
  function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] keep);
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      m[i*8 +: 8] = {8{keep[i]}};
    end
    return m;
  endfunction

  state_t                  state_r, state_s;
  logic [DATA_WD-1:0]      res_data_r, res_data_s;   // residual bytes, MSB-aligned
  logic [SW-1:0]           res_cnt_r, res_cnt_s;     // residual byte count R

  logic                    out_free_s;
  logic                    accept_s;
  logic [SW-1:0]           n_s;
  logic [DATA_WD-1:0]      din_s;
  logic [CW-1:0]           k_s;
  logic [CW-1:0]           total_s;
  logic [2*DATA_WD-1:0]    merged_s;

  logic                    load_s;
  logic [DATA_WD-1:0]      ld_data_s;
  logic [DATA_BYTE_WD-1:0] ld_keep_s;
  logic                    ld_last_s;
  logic                    drop_s;

  assign out_free_s    = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state_r != ST_FLUSH) && out_free_s;
  assign accept_s      = s_axis_tvalid && s_axis_tready;
  assign n_s           = (strip_len > W_CNT) ? W_CNT : strip_len;
  assign din_s         = s_axis_tdata & byte_mask(s_axis_tkeep);
  assign k_s           = count_keep(s_axis_tkeep);
  assign total_s       = CW'(res_cnt_r) + k_s;
  // residual followed by the new beat; upper half is the next output beat,
  // lower half is what is left over for the following one
  assign merged_s      = {res_data_r, {DATA_WD{1'b0}}}
                       | ({din_s, {DATA_WD{1'b0}}} >> {res_cnt_r, 3'b000});

  // next-state, residual and output-load decisions
  always_comb begin
    state_s    = state_r;
    res_data_s = res_data_r;
    res_cnt_s  = res_cnt_r;
    load_s     = 1'b0;
    ld_data_s  = '0;
    ld_keep_s  = '0;
    ld_last_s  = 1'b0;
    drop_s     = 1'b0;
    case (state_r)
      ST_FIRST: begin
        if (accept_s) begin
          if (s_axis_tlast) begin
            if (k_s <= CW'(n_s)) begin
              drop_s = 1'b1;
            end else begin
              load_s    = 1'b1;
              ld_data_s = din_s << {n_s, 3'b000};
              ld_keep_s = s_axis_tkeep << n_s;
              ld_last_s = 1'b1;
            end
            res_data_s = '0;
            res_cnt_s  = '0;
            state_s    = ST_FIRST;
          end else begin
            if (n_s == {SW{1'b0}}) begin
              load_s     = 1'b1;
              ld_data_s  = din_s;
              ld_keep_s  = s_axis_tkeep;
              ld_last_s  = 1'b0;
              res_data_s = '0;
              res_cnt_s  = '0;
            end else begin
              // n = W leaves nothing behind: R = 0, pure pass-through next
              res_data_s = din_s << {n_s, 3'b000};
              res_cnt_s  = W_CNT - n_s;
            end
            state_s = ST_MERGE;
          end
        end else begin
          state_s = ST_FIRST;
        end
      end
      ST_MERGE: begin
        if (accept_s) begin
          if (res_cnt_r == {SW{1'b0}}) begin
            load_s    = 1'b1;
            ld_data_s = din_s;
            ld_keep_s = s_axis_tkeep;
            ld_last_s = s_axis_tlast;
            state_s   = s_axis_tlast ? ST_FIRST : ST_MERGE;
          end else if (s_axis_tlast) begin
            load_s    = 1'b1;
            ld_data_s = merged_s[2*DATA_WD-1:DATA_WD];
            if (total_s <= CW'(DATA_BYTE_WD)) begin
              ld_keep_s  = keep_of(total_s);
              ld_last_s  = 1'b1;
              res_data_s = '0;
              res_cnt_s  = '0;
              state_s    = ST_FIRST;
            end else begin
              ld_keep_s  = {DATA_BYTE_WD{1'b1}};
              ld_last_s  = 1'b0;
              res_data_s = merged_s[DATA_WD-1:0];
              res_cnt_s  = SW'(total_s - CW'(DATA_BYTE_WD));
              state_s    = ST_FLUSH;
            end
          end else begin
            load_s     = 1'b1;
            ld_data_s  = merged_s[2*DATA_WD-1:DATA_WD];
            ld_keep_s  = {DATA_BYTE_WD{1'b1}};
            ld_last_s  = 1'b0;
            res_data_s = merged_s[DATA_WD-1:0];
            state_s    = ST_MERGE;
          end
        end else begin
          state_s = ST_MERGE;
        end
      end
      ST_FLUSH: begin
        if (out_free_s) begin
          load_s     = 1'b1;
          ld_data_s  = res_data_r;
          ld_keep_s  = keep_of(CW'(res_cnt_r));
          ld_last_s  = 1'b1;
          res_data_s = '0;
          res_cnt_s  = '0;
          state_s    = ST_FIRST;
        end else begin
          state_s = ST_FLUSH;
        end
      end
      default: begin
        res_data_s = '0;
        res_cnt_s  = '0;
        state_s    = ST_FIRST;
      end
    endcase
  end

  // state and residual registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_FIRST;
      res_data_r <= '0;
      res_cnt_r  <= '0;
    end else begin
      state_r    <= state_s;
      res_data_r <= res_data_s;
      res_cnt_r  <= res_cnt_s;
    end
  end

  // output register: load a new beat, retire on handshake, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      drop_pulse    <= 1'b0;
    end else begin
      if (load_s) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= ld_data_s;
        m_axis_tkeep  <= ld_keep_s;
        m_axis_tlast  <= ld_last_s;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end else begin
        m_axis_tvalid <= m_axis_tvalid;
      end
      drop_pulse <= drop_s;
    end
  end

`ifdef AXIS_RM_HDR_STAT_EN
  // statistics: emitted packets and fully dropped packets, wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt  <= 16'd0;
      drop_cnt <= 16'd0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        pkt_cnt <= pkt_cnt + 16'd1;
      end else begin
        pkt_cnt <= pkt_cnt;
      end
      if (drop_pulse) begin
        drop_cnt <= drop_cnt + 16'd1;
      end else begin
        drop_cnt <= drop_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_stream_remove_header.sv
// Scoreboard bench for axi_stream_remove_header (W = 4).
// Reference model: a packet is a byte list; strip min(N,W) leading bytes,
// then chop the rest into MSB-aligned 4-byte beats (last beat partial).
module tb_axi_stream_remove_header;
  localparam int DW = 32;
  localparam int W  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    strip_len = 3'd0;
  logic          s_axis_tvalid = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [W-1:0]  s_axis_tkeep = '0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic [W-1:0]  m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic          drop_pulse;
`ifdef AXIS_RM_HDR_STAT_EN
  logic [15:0]   pkt_cnt;
  logic [15:0]   drop_cnt;
`endif

  axi_stream_remove_header #(.DATA_WD(DW), .DATA_BYTE_WD(W)) dut (
    .clk(clk), .rst_n(rst_n), .strip_len(strip_len),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .drop_pulse(drop_pulse)
`ifdef AXIS_RM_HDR_STAT_EN
    , .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [W-1:0]  k;
    logic          l;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] pkt_b[$];
  int total = 0;
  int bad = 0;
  int exp_drops = 0;
  int seen_drops = 0;
  int st_pkts = 0;
  int st_drops = 0;
  int rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // reference model: byte-level strip and re-pack
  task automatic model_push(input int nreq);
    int n, len, rem, idx, c;
    beat_t e;
    n = (nreq > W) ? W : nreq;
    len = pkt_b.size();
    if (len <= n) begin
      exp_drops++;
    end else begin
      rem = len - n;
      idx = n;
      while (rem > 0) begin
        c = (rem > W) ? W : rem;
        e.d = '0;
        e.k = '0;
        for (int j = 0; j < c; j++) begin
          e.d[DW-1-8*j -: 8] = pkt_b[idx+j];
          e.k[W-1-j] = 1'b1;
        end
        e.l = (rem <= W);
        exp_q.push_back(e);
        idx += c;
        rem -= c;
      end
    end
  endtask

  task automatic send_pkt(input int nreq, input int gap_max, input bit mid_rand, input bit stall_end);
    int len, nb, cyc, c;
    bit hs;
    logic [DW-1:0] d;
    logic [W-1:0]  k;
    len = pkt_b.size();
    nb = (len + W - 1) / W;
    model_push(nreq);
    for (int b = 0; b < nb; b++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          s_axis_tvalid = 1'b0;
          @(posedge clk); #1;
        end
      end
      d = $urandom;
      k = '0;
      c = (len - b*W > W) ? W : len - b*W;
      for (int j = 0; j < c; j++) begin
        d[DW-1-8*j -: 8] = pkt_b[b*W+j];
        k[W-1-j] = 1'b1;
      end
      strip_len     = (b == 0 || !mid_rand) ? 3'(nreq) : 3'($urandom_range(0, 7));
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = (b == nb - 1);
      hs = 1'b0;
      cyc = 0;
      while (!hs && cyc < 300) begin
        @(negedge clk);
        hs = s_axis_tready;
        if (hs && stall_end && b == nb - 1) rdy_mode = 2;
        @(posedge clk); #1;
        cyc++;
      end
      if (!hs) begin
        total++;
        bad++;
        $display("FAIL handshake_timeout actual=no_ready required=ready_within_300");
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 2000) begin
      @(posedge clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d_pending required=0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  // output-ready generator
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_axis_tready = ($urandom_range(0, 3) != 0);
      1:       m_axis_tready = 1'b1;
      default: m_axis_tready = 1'b0;
    endcase
  end

  // monitor: scoreboard pop, hold stability, ready rule, drop counting
  initial begin
    beat_t e;
    logic [DW+W:0] held;
    bit hold_pend;
    hold_pend = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pend = 1'b0;
        st_pkts = 0;
        st_drops = 0;
      end else begin
        if (hold_pend) begin
          check("hold_valid", 64'(m_axis_tvalid), 64'd1);
          check("hold_data", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 64'(held));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL beat_unexpected actual=%h/%h/%b required=none",
                     m_axis_tdata, m_axis_tkeep, m_axis_tlast);
          end else begin
            e = exp_q.pop_front();
            check("beat", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 64'(e));
          end
          if (m_axis_tlast) st_pkts++;
        end
        if (m_axis_tvalid && !m_axis_tready) begin
          check("ready_rule", 64'(s_axis_tready), 64'd0);
          hold_pend = 1'b1;
          held = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
        end else begin
          hold_pend = 1'b0;
        end
        if (drop_pulse) begin
          seen_drops++;
          st_drops++;
        end
      end
    end
  end

  // watchdog
  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_drop", 64'(drop_pulse), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'(s_axis_tready), 64'd1);
    @(posedge clk); #2;

    // N=0 single beat: one-cycle latency
    pkt_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_pkt(0, 0, 1'b0, 1'b0);
    @(negedge clk);
    check("latency_n0", 64'(m_axis_tvalid), 64'd1);
    drain();

    // N=0 two beats pass unchanged
    pkt_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_pkt(0, 0, 1'b0, 1'b0);
    drain();

    // N=2 two full beats -> full beat + 2-byte last beat
    pkt_b = '{8'hAA, 8'hBB, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_pkt(2, 0, 1'b0, 1'b0);
    drain();

    // N=1, last keep E -> FLUSH; ready must be low in FLUSH
    pkt_b = '{8'hAA, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_pkt(1, 0, 1'b0, 1'b0);
    @(negedge clk);
    check("flush_ready", 64'(s_axis_tready), 64'd0);
    drain();

    // N=2 with output stalled 3 cycles while in FLUSH
    pkt_b = '{8'hAA, 8'hBB, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hA0};
    send_pkt(2, 0, 1'b0, 1'b1);
    @(negedge clk);
    check("stall_flush_ready", 64'(s_axis_tready), 64'd0);
    repeat (3) @(posedge clk);
    rdy_mode = 1;
    drain();

    // N=3, single 3-byte beat -> whole packet dropped
    pkt_b = '{8'hAA, 8'hBB, 8'hCC};
    send_pkt(3, 0, 1'b0, 1'b0);
    @(negedge clk);
    check("drop_pulse_hi", 64'(drop_pulse), 64'd1);
    @(negedge clk);
    check("drop_pulse_lo", 64'(drop_pulse), 64'd0);
    drain();

    // reset mid-packet with an output beat pending
    rdy_mode = 2;
    @(posedge clk); #2;
    strip_len = 3'd0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 32'hAABB1122;
    s_axis_tkeep = 4'hF;
    s_axis_tlast = 1'b0;
    @(negedge clk);
    check("pre_rst_ready", 64'(s_axis_tready), 64'd1);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("arst_tdata", 64'(m_axis_tdata), 64'd0);
    check("arst_tkeep", 64'(m_axis_tkeep), 64'd0);
    check("arst_tlast", 64'(m_axis_tlast), 64'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rdy_mode = 1;
    @(posedge clk); #2;
    pkt_b = '{8'hAA, 8'hBB, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_pkt(2, 0, 1'b0, 1'b0);
    drain();

    // randomized packets, random strip_len (incl. >W), gaps and back-pressure
    rdy_mode = 0;
    for (int p = 0; p < 200; p++) begin
      int len;
      len = $urandom_range(1, 13);
      pkt_b.delete();
      repeat (len) pkt_b.push_back(8'($urandom));
      send_pkt($urandom_range(0, 7), 2, 1'b1, 1'b0);
    end
    rdy_mode = 1;
    drain();
    repeat (3) @(posedge clk);
    check("drop_count", 64'(seen_drops), 64'(exp_drops));
`ifdef AXIS_RM_HDR_STAT_EN
    @(negedge clk);
    check("stat_pkt_cnt", 64'(pkt_cnt), 64'(st_pkts));
    check("stat_drop_cnt", 64'(drop_cnt), 64'(st_drops));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
